uart_tx_scheduler: RTL and testbench

- Shares one UART transmitter (start/busy/done byte interface) between NUM_REQ byte sources, using round-robin arbitration.
- Each granted byte is optionally sent after a channel-ID header byte, so the far-end receiver can demultiplex the stream.
- Sits between board-level data sources (switch banks, counters, sensors) and the transmitter half of the UART top.
- Includes a watchdog that abandons a transfer if the transmitter never reports completion.

---
 rtl/uart_tx_scheduler_pkg.sv | 23 ++
 rtl/uart_tx_scheduler_rr_arbiter.sv | 31 +++
 rtl/uart_tx_scheduler.sv | 127 ++++++++++++
 tb/tb_uart_tx_scheduler.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_scheduler_pkg.sv
// Shared definitions for the UART transmit scheduler.
//   state_t      : 3-bit FSM state encoding
//   DEF_DATA_W   : default byte width
//   DEF_HDR_BASE : default channel header base value
//   idx_w()      : index width for a given requester count (at least 1 bit)
package uart_tx_scheduler_pkg;

  localparam int         DEF_DATA_W   = 8;
  localparam logic [7:0] DEF_HDR_BASE = 8'hA0;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_HDR_START = 3'd1,
    ST_HDR_WAIT  = 3'd2,
    ST_DAT_START = 3'd3,
    ST_DAT_WAIT  = 3'd4
  } state_t;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick.
//   req   : request vector
//   last  : index granted most recently; the search starts just after it
//   valid : at least one request is set
//   idx   : first set request found searching from last+1 with wrap-around
module rr_arbiter
  import uart_tx_scheduler_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  // Scan from the farthest candidate to the nearest so that the nearest
  // set bit after 'last' is the one left standing.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = N; k >= 1; k--) begin
      if (req[(int'(last) + k) % N]) begin
        valid = 1'b1;
        idx   = IDX_W'((int'(last) + k) % N);
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter between NUM_REQ byte sources, round-robin.
// Each grant optionally sends a channel header (HDR_BASE | grant_id) before
// the data byte; a watchdog abandons a byte if tx_done never arrives.
//   clk, rst         : clock, synchronous active-high reset
//   req, req_data    : per-requester request level and flattened bytes
//   ack              : one-cycle one-hot pulse, requester's byte latched
//   tx_start/tx_data : start pulse and byte to the transmitter
//   tx_busy/tx_done  : transmitter busy level and completion pulse
//   grant_id         : current/last granted requester
//   active           : scheduler not idle
//   timeout_err      : one-cycle pulse when the watchdog fires
//
// state     | meaning
// ----------+--------------------------------------------
// IDLE      | waiting for a request with transmitter free
// HDR_START | header byte presented, tx_start high
// HDR_WAIT  | waiting for tx_done of the header
// DAT_START | data byte presented, tx_start high
// DAT_WAIT  | waiting for tx_done of the data byte
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int                NUM_REQ        = 4,
  parameter int                DATA_W         = DEF_DATA_W,
  parameter int                HEADER_EN      = 1,
  parameter logic [DATA_W-1:0] HDR_BASE       = DATA_W'(DEF_HDR_BASE),
  parameter int                TIMEOUT_CYCLES = 100000,
  localparam int               IDX_W          = idx_w(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_busy,
  input  logic                      tx_done,
  output logic [IDX_W-1:0]          grant_id,
  output logic                      active,
  output logic                      timeout_err
);

  localparam int TMR_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = '1;

  state_t               state;
  logic [DATA_W-1:0]    data_q;
  logic [IDX_W-1:0]     grant_q;
  logic [IDX_W-1:0]     last_grant;
  logic [NUM_REQ-1:0]   ack_q;
  logic                 timeout_q;
  logic [TMR_W-1:0]     timer;
  logic                 arb_valid;
  logic [IDX_W-1:0]     arb_idx;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req   (req),
    .last  (last_grant),
    .valid (arb_valid),
    .idx   (arb_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      data_q     <= '0;
      grant_q    <= '0;
      last_grant <= IDX_W'(NUM_REQ - 1);
      ack_q      <= '0;
      timeout_q  <= 1'b0;
      timer      <= '0;
    end else begin
      ack_q     <= '0;
      timeout_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (arb_valid && !tx_busy) begin
            data_q  <= req_data[int'(arb_idx)*DATA_W +: DATA_W];
            grant_q <= arb_idx;
            ack_q   <= NUM_REQ'(1) << arb_idx;
            state   <= (HEADER_EN != 0) ? ST_HDR_START : ST_DAT_START;
          end
        end
        ST_HDR_START: begin
          state <= ST_HDR_WAIT;
          timer <= '0;
        end
        ST_DAT_START: begin
          state <= ST_DAT_WAIT;
          timer <= '0;
        end
        ST_HDR_WAIT, ST_DAT_WAIT: begin
          // tx_done has priority over a watchdog expiry on the same edge
          if (tx_done) begin
            if (state == ST_HDR_WAIT) begin
              state <= ST_DAT_START;
            end else begin
              state      <= ST_IDLE;
              last_grant <= grant_q;
            end
          end else if ((TIMEOUT_CYCLES != 0) && (timer == TMR_LAST)) begin
            timeout_q  <= 1'b1;
            state      <= ST_IDLE;
            last_grant <= grant_q;
          end else if (timer != TMR_MAX) begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign tx_start    = (state == ST_HDR_START) || (state == ST_DAT_START);
  assign tx_data     = (state == ST_HDR_START) ? (HDR_BASE | DATA_W'(grant_q)) :
                       (state == ST_DAT_START) ? data_q : '0;
  assign active      = (state != ST_IDLE);
  assign ack         = ack_q;
  assign grant_id    = grant_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
module tb_uart_tx_scheduler;

  localparam int NR = 4;
  localparam int T  = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic        tx_busy = 1'b0, tx_done = 1'b0;
  logic [3:0]  ack;
  logic        tx_start, active, timeout_err;
  logic [7:0]  tx_data;
  logic [1:0]  grant_id;

  logic        tx_busy0 = 1'b0, tx_done0 = 1'b0;
  logic [3:0]  ack0;
  logic        tx_start0, active0, timeout_err0;
  logic [7:0]  tx_data0;
  logic [1:0]  grant_id0;

  uart_tx_scheduler #(.NUM_REQ(4), .DATA_W(8), .HEADER_EN(1), .HDR_BASE(8'hA0),
                      .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .tx_done(tx_done),
    .grant_id(grant_id), .active(active), .timeout_err(timeout_err));

  uart_tx_scheduler #(.NUM_REQ(4), .DATA_W(8), .HEADER_EN(0), .HDR_BASE(8'hA0),
                      .TIMEOUT_CYCLES(T)) dut0 (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack0),
    .tx_start(tx_start0), .tx_data(tx_data0), .tx_busy(tx_busy0), .tx_done(tx_done0),
    .grant_id(grant_id0), .active(active0), .timeout_err(timeout_err0));

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
  endtask

  // ---------------- transmitter model and reference model ----------------
  int  tx_cnt     = 0;
  int  tx_lat     = 10;
  bit  rnd_lat    = 0;
  bit  force_busy = 0;
  bit  no_done    = 0;

  // Reference: a byte-level view of the link. phase 0 = nothing pending,
  // 1 = header being handed over, 2 = header on the wire, 3 = data being
  // handed over, 4 = data on the wire. 'left' is the watchdog allowance.
  bit         m_on = 0;
  int         m_phase, m_left, m_last, m_gid;
  logic [7:0] m_byte;
  logic [3:0] e_ack;
  logic       e_to;

  function automatic int rr_pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= NR; k++)
      if (r[(last + k) % NR]) return (last + k) % NR;
    return -1;
  endfunction

  task automatic model_step();
    int g;
    e_ack = '0;
    e_to  = 1'b0;
    if (rst) begin
      m_on = 1; m_phase = 0; m_last = NR - 1; m_gid = 0; m_byte = '0;
      return;
    end
    if (!m_on) return;
    case (m_phase)
      0: if (req != 0 && !tx_busy) begin
           g = rr_pick(req, m_last);
           m_gid = g;
           m_byte = req_data[g*8 +: 8];
           e_ack = 4'(1 << g);
           m_phase = 1;
         end
      1, 3: begin m_phase = m_phase + 1; m_left = T; end
      default: begin
        if (tx_done) begin
          if (m_phase == 2) m_phase = 3;
          else begin m_phase = 0; m_last = m_gid; end
        end else begin
          m_left--;
          if (m_left == 0) begin e_to = 1'b1; m_phase = 0; m_last = m_gid; end
        end
      end
    endcase
  endtask

  function automatic logic [16:0] expected_outs();
    logic       st;
    logic [7:0] d;
    st = (m_phase == 1) || (m_phase == 3);
    d  = (m_phase == 1) ? (8'hA0 | 8'(m_gid)) : (m_phase == 3) ? m_byte : 8'h00;
    return {e_ack, st, d, 2'(m_gid), m_phase != 0, e_to};
  endfunction

  initial forever begin
    @(negedge clk);
    if (m_on) check("cycle", 64'({ack, tx_start, tx_data, grant_id, active, timeout_err}),
                    64'(expected_outs()));
    tx_done = 1'b0;
    if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) tx_done = 1'b1;
    end
    if (tx_start === 1'b1 && !no_done) begin
      if (rnd_lat) tx_cnt = ($urandom_range(0, 11) == 0) ? 60 : int'($urandom_range(1, 12));
      else tx_cnt = tx_lat;
    end
    tx_busy = force_busy || (tx_cnt > 0);
    model_step();
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sig(input int which, input int budget, input string name, output int cyc);
    bit hit;
    hit = 0;
    cyc = 0;
    while (!hit && cyc < budget) begin
      tick();
      cyc++;
      case (which)
        0: hit = (ack != 0);
        1: hit = (tx_start == 1'b1);
        2: hit = (active == 1'b0);
        3: hit = (timeout_err == 1'b1);
        default: hit = (ack0 != 0);
      endcase
    end
    if (!hit) begin
      n_checks++;
      $display("FAIL %s: no event within %0d cycles", name, budget);
    end
  endtask

  task automatic do_reset();
    req = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 100 && tx_busy; i++) tick();
  endtask

  typedef struct {
    logic [3:0]  r;
    logic [31:0] d;
    logic [3:0]  e_ack;
    logic [7:0]  e_hdr;
    logic [7:0]  e_dat;
    logic [1:0]  e_gid;
  } vec_t;

  vec_t       vt[5];
  logic [7:0] seq_exp[10];
  logic [3:0] ack_exp[5];
  logic [3:0] ws_exp[3];
  logic [7:0] ws_dat[3];

  initial begin
    int c, cnt, nb, na;
    vt[0] = '{4'b0100, 32'h005A_0000, 4'b0100, 8'hA2, 8'h5A, 2'd2};
    vt[1] = '{4'b1111, 32'h1312_1110, 4'b0001, 8'hA0, 8'h10, 2'd0};
    vt[2] = '{4'b1000, 32'h3300_0000, 4'b1000, 8'hA3, 8'h33, 2'd3};
    vt[3] = '{4'b0110, 32'h0022_2100, 4'b0010, 8'hA1, 8'h21, 2'd1};
    vt[4] = '{4'b1010, 32'h4300_4100, 4'b0010, 8'hA1, 8'h41, 2'd1};
    seq_exp = '{8'hA0, 8'h10, 8'hA1, 8'h11, 8'hA2, 8'h12, 8'hA3, 8'h13, 8'hA0, 8'h10};
    ack_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    ws_exp  = '{4'b0010, 4'b1000, 4'b0010};
    ws_dat  = '{8'h41, 8'h43, 8'h41};

    tick(); tick();
    check("reset_outputs", 64'({ack, tx_start, tx_data, grant_id, active, timeout_err}), 64'd0);
    rst = 1'b0;

    // single-grant vectors, each from reset (requester 0 has first priority)
    foreach (vt[v]) begin
      do_reset();
      req = vt[v].r;
      req_data = vt[v].d;
      wait_sig(0, 20, "vec_ack_wait", c);
      check("vec_ack", 64'(ack), 64'(vt[v].e_ack));
      check("vec_hdr", 64'({tx_start, tx_data}), 64'({1'b1, vt[v].e_hdr}));
      check("vec_gid", 64'(grant_id), 64'(vt[v].e_gid));
      req = '0;
      wait_sig(1, 30, "vec_dat_wait", c);
      check("vec_dat", 64'({ack, tx_data}), 64'({4'b0000, vt[v].e_dat}));
      wait_sig(2, 30, "vec_idle_wait", c);
      check("vec_idle_latency", 64'(c), 64'd11);
      check("vec_gid_hold", 64'(grant_id), 64'(vt[v].e_gid));
    end

    // round-robin fairness with all requesters held
    do_reset();
    req = 4'b1111;
    req_data = 32'h1312_1110;
    for (int i = 0; i < 10; i++) begin
      wait_sig(1, 40, "rr_wait", c);
      check("rr_byte", 64'(tx_data), 64'(seq_exp[i]));
      if (i % 2 == 0) check("rr_ack", 64'(ack), 64'(ack_exp[i/2]));
    end
    req = '0;

    // wrap and skip, header on
    do_reset();
    req = 4'b1010;
    req_data = 32'h4300_4100;
    for (int i = 0; i < 3; i++) begin
      wait_sig(0, 40, "ws_wait", c);
      check("ws_ack", 64'(ack), 64'(ws_exp[i]));
    end

    // wrap and skip, header off: one tx_start per grant
    do_reset();
    req = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      wait_sig(4, 20, "nohdr_wait", c);
      check("nohdr_ack_data", 64'({ack0, tx_start0, tx_data0}), 64'({ws_exp[i], 1'b1, ws_dat[i]}));
      cnt = 0;
      for (int k = 0; k < 3; k++) begin tick(); if (tx_start0) cnt++; end
      check("nohdr_single_start", 64'(cnt), 64'd0);
      tx_done0 = 1'b1;
      tick();
      tx_done0 = 1'b0;
    end
    req = '0;

    // busy gating, then watchdog
    do_reset();
    force_busy = 1;
    req = 4'b0001;
    req_data = 32'h0000_0077;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin tick(); if (ack != 0 || active) cnt++; end
    check("busy_no_grant", 64'(cnt), 64'd0);
    force_busy = 0;
    no_done = 1;
    wait_sig(0, 10, "to_ack_wait", c);
    check("to_ack", 64'(ack), 64'b0001);
    req = 4'b0010;
    req_data = 32'h0000_8800;
    wait_sig(3, 80, "to_wait", c);
    check("to_latency", 64'(c), 64'd51);
    check("to_idle", 64'({active, tx_start}), 64'd0);
    wait_sig(0, 5, "to_next_wait", c);
    check("to_next_grant", 64'({ack, 8'(c)}), 64'({4'b0010, 8'd1}));
    req = '0;
    no_done = 0;

    // reset in the middle of the data byte
    do_reset();
    req = 4'b0001;
    req_data = 32'h0000_0055;
    wait_sig(0, 10, "mr_ack_wait", c);
    req = '0;
    wait_sig(1, 30, "mr_dat_wait", c);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr_outputs", 64'({ack, tx_start, tx_data, grant_id, active, timeout_err}), 64'd0);
    cnt = 0;
    for (int k = 0; k < 12; k++) begin tick(); if (active || tx_start) cnt++; end
    check("mr_late_done_ignored", 64'(cnt), 64'd0);
    req = 4'b0011;
    req_data = 32'h0000_6566;
    wait_sig(0, 10, "mr_next_wait", c);
    check("mr_next_grant", 64'({ack, tx_data}), 64'({4'b0001, 8'hA0}));
    req = '0;

    // randomized traffic checked cycle by cycle against the reference model
    do_reset();
    rnd_lat = 1;
    na = 0;
    nb = 0;
    for (int n = 0; n < 5000; n++) begin
      tick();
      rst = 1'b0;
      for (int i = 0; i < NR; i++) begin
        if (ack[i]) begin
          na++;
          if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
          else req_data[i*8 +: 8] = 8'($urandom);
        end else if (!req[i] && $urandom_range(0, 7) == 0) begin
          req[i] = 1'b1;
          req_data[i*8 +: 8] = 8'($urandom);
        end
      end
      if (timeout_err) nb++;
      if ($urandom_range(0, 799) == 0) rst = 1'b1;
    end
    rst = 1'b0;
    req = '0;
    check("rnd_grants_seen", 64'(na > 50), 64'd1);
    rnd_lat = 0;
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
